// File: rtl/shared_compute_unit.sv
// Shared vector/matrix arithmetic engine: element-wise ADD/SUB/MUL in 1 compute cycle, MATVEC one row per cycle.
// Latency accept->done: 2 cycles element-wise, VEC_LEN+1 for MATVEC; requests while busy are dropped, not queued.
module shared_compute_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int VEC_LEN    = 4,
  parameter int FRAC_BITS  = 0,
  parameter int ID_WIDTH   = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [ID_WIDTH-1:0]                     unit_id,
  input  logic                                    request,
  output logic                                    ready,
  output logic                                    done,
  input  logic [1:0]                              comp_type,
  input  logic [VEC_LEN*DATA_WIDTH-1:0]           vector_a,
  input  logic [VEC_LEN*DATA_WIDTH-1:0]           vector_b,
  input  logic [VEC_LEN*VEC_LEN*DATA_WIDTH-1:0]   matrix_in,
  output logic [VEC_LEN*DATA_WIDTH-1:0]           result,
  output logic [ID_WIDTH-1:0]                     result_id
);
  localparam int DW    = DATA_WIDTH;
  localparam int RW    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int ACC_W = 2*DW + RW;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_MUL = 2'd1, OP_MATVEC = 2'd2, OP_SUB = 2'd3} op_e;

  state_e                              state_q, state_d;
  op_e                                 op_q, op_d;
  logic [ID_WIDTH-1:0]                 id_q, id_d;
  logic [VEC_LEN*DW-1:0]               a_q, a_d, b_q, b_d;
  logic [VEC_LEN*VEC_LEN*DW-1:0]       m_q, m_d;
  logic [RW-1:0]                       row_q, row_d;
  logic [VEC_LEN*DW-1:0]               buf_q, buf_d;
  logic [VEC_LEN*DW-1:0]               result_q, result_d;
  logic [ID_WIDTH-1:0]                 rid_q, rid_d;

  logic [VEC_LEN*DW-1:0]               ew_res;
  logic signed [ACC_W-1:0]             mv_term [VEC_LEN];
  logic signed [ACC_W-1:0]             mv_acc;
  logic [DW-1:0]                       row_sat;

  function automatic logic [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return v[DW-1:0];
  endfunction

  for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
    logic signed [DW-1:0]    ea, eb;
    logic signed [2*DW-1:0]  ea2, eb2, prod, prod_sh;
    logic signed [ACC_W-1:0] wa, wb, wp, wide;
    assign ea      = a_q[i*DW +: DW];
    assign eb      = b_q[i*DW +: DW];
    assign ea2     = {{DW{ea[DW-1]}}, ea};
    assign eb2     = {{DW{eb[DW-1]}}, eb};
    assign prod    = ea2 * eb2;
    assign prod_sh = prod >>> FRAC_BITS;
    assign wa      = {{(ACC_W-DW){ea[DW-1]}}, ea};
    assign wb      = {{(ACC_W-DW){eb[DW-1]}}, eb};
    assign wp      = {{(ACC_W-2*DW){prod_sh[2*DW-1]}}, prod_sh};
    always_comb begin
      wide = '0;
      case (op_q)
        OP_ADD:  wide = wa + wb;
        OP_SUB:  wide = wa - wb;
        OP_MUL:  wide = wp;
        default: wide = '0;
      endcase
    end
    assign ew_res[i*DW +: DW] = sat(wide);
  end

  // One matrix row per cycle; each product is scaled before accumulation.
  for (genvar c = 0; c < VEC_LEN; c++) begin : g_col
    logic signed [DW-1:0]   mc, ac;
    logic signed [2*DW-1:0] mc2, ac2, mp, mp_sh;
    assign mc    = m_q[(int'(row_q)*VEC_LEN + c)*DW +: DW];
    assign ac    = a_q[c*DW +: DW];
    assign mc2   = {{DW{mc[DW-1]}}, mc};
    assign ac2   = {{DW{ac[DW-1]}}, ac};
    assign mp    = mc2 * ac2;
    assign mp_sh = mp >>> FRAC_BITS;
    assign mv_term[c] = {{(ACC_W-2*DW){mp_sh[2*DW-1]}}, mp_sh};
  end

  always_comb begin
    mv_acc = '0;
    for (int c = 0; c < VEC_LEN; c++) mv_acc = mv_acc + mv_term[c];
  end
  assign row_sat = sat(mv_acc);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    row_d    = row_q;
    buf_d    = buf_q;
    result_d = result_q;
    rid_d    = rid_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          op_d    = op_e'(comp_type);
          id_d    = unit_id;
          a_d     = vector_a;
          b_d     = vector_b;
          m_d     = matrix_in;
          row_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (op_q != OP_MATVEC) begin
          result_d = ew_res;
          rid_d    = id_q;
          state_d  = DONE;
        end else begin
          buf_d[int'(row_q)*DW +: DW] = row_sat;
          if (row_q == RW'(VEC_LEN-1)) begin
            result_d = buf_d;
            rid_d    = id_q;
            row_d    = '0;
            state_d  = DONE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      row_q    <= '0;
      buf_q    <= '0;
      result_q <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      row_q    <= row_d;
      buf_q    <= buf_d;
      result_q <= result_d;
      rid_q    <= rid_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign result_id = rid_q;
endmodule

// File: tb/tb_shared_compute_unit.sv
// Directed bench for shared_compute_unit: table of jobs plus hand-written busy, reset-abort and fixed-point sequences.
module tb_shared_compute_unit;
  localparam logic [1:0] ADD = 2'd0, MUL = 2'd1, MV = 2'd2, SUB = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   unit_id;
  logic         request, request1;
  logic [1:0]   comp_type;
  logic [63:0]  vector_a, vector_b;
  logic [255:0] matrix_in;
  logic         ready, done, ready1, done1;
  logic [63:0]  result, result1;
  logic [7:0]   result_id, result_id1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [1:0]   op;
    logic [7:0]   id;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [255:0] m;
    logic [63:0]  exp;
  } vec_t;
  vec_t tv[8];

  shared_compute_unit #(.DATA_WIDTH(16), .VEC_LEN(4), .FRAC_BITS(0), .ID_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .unit_id(unit_id), .request(request), .ready(ready), .done(done),
    .comp_type(comp_type), .vector_a(vector_a), .vector_b(vector_b), .matrix_in(matrix_in),
    .result(result), .result_id(result_id)
  );

  shared_compute_unit #(.DATA_WIDTH(16), .VEC_LEN(4), .FRAC_BITS(8), .ID_WIDTH(8)) dut_q8 (
    .clk(clk), .rst_n(rst_n), .unit_id(unit_id), .request(request1), .ready(ready1), .done(done1),
    .comp_type(comp_type), .vector_a(vector_a), .vector_b(vector_b), .matrix_in(matrix_in),
    .result(result1), .result_id(result_id1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [63:0] p4(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  function automatic logic [255:0] mrows(input logic [63:0] r0, input logic [63:0] r1,
                                         input logic [63:0] r2, input logic [63:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the unit idle; ends at the negedge after done.
  task automatic run_job(input vec_t v, input logic [63:0] prev, input string tag);
    int lat;
    int done_at;
    lat = (v.op == MV) ? 5 : 2;
    comp_type = v.op; unit_id = v.id; vector_a = v.a; vector_b = v.b; matrix_in = v.m;
    request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    chk({tag, " ready_busy"}, 64'(ready), 64'd0);
    vector_a = ~v.a; vector_b = ~v.b; matrix_in = ~v.m; unit_id = ~v.id; comp_type = ~v.op;
    done_at = 0;
    for (int k = 1; k <= 8 && done_at == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (done === 1'b1) begin
        done_at = k;
        chk({tag, " result"}, result, v.exp);
        chk({tag, " result_id"}, 64'(result_id), 64'(v.id));
      end else begin
        chk({tag, " result_hold"}, result, prev);
      end
    end
    chk({tag, " done_cycle"}, 64'(done_at), 64'(lat));
    @(negedge clk);
    chk({tag, " ready_after"}, 64'(ready), 64'd1);
    chk({tag, " done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] prev;
    int c0;
    rst_n = 1'b1; request = 1'b0; request1 = 1'b0; unit_id = '0; comp_type = '0;
    vector_a = '0; vector_b = '0; matrix_in = '0;

    tv[0] = '{ADD, 8'd5, p4(1, 2, 3, 4), p4(10, 20, 30, 40), '0, p4(11, 22, 33, 44)};
    tv[1] = '{SUB, 8'd6, p4(-32768, 100, 0, 7), p4(1, -32767, 5, 7), '0, p4(-32768, 32767, -5, 0)};
    tv[2] = '{MUL, 8'd7, p4(3, -2, 100, 0), p4(4, 5, 400, 7), '0, p4(12, -10, 32767, 0)};
    tv[3] = '{ADD, 8'd8, p4(32767, -32768, -1, 1000), p4(1, -1, -1, -3000), '0, p4(32767, -32768, -2, -2000)};
    tv[4] = '{MUL, 8'd9, p4(-300, -1, -32768, 181), p4(200, -1, -32768, 181), '0, p4(-32768, 1, 32767, 32761)};
    tv[5] = '{MV, 8'd10, p4(1, 2, 3, 4), p4(99, 99, 99, 99),
              mrows(p4(2, 0, 0, 0), p4(0, 2, 0, 0), p4(0, 0, 2, 0), p4(0, 0, 0, 2)), p4(2, 4, 6, 8)};
    tv[6] = '{MV, 8'd11, p4(2, 2, 2, 2), '0,
              mrows(p4(16384, 16384, 16384, 16384), p4(16384, 16384, 16384, 16384),
                    p4(16384, 16384, 16384, 16384), p4(16384, 16384, 16384, 16384)),
              p4(32767, 32767, 32767, 32767)};
    tv[7] = '{MV, 8'd12, p4(5, -3, 2, 1), p4(1, 1, 1, 1),
              mrows(p4(1, 2, 3, 4), p4(-1, -1, -1, -1), p4(0, 0, 0, 0),
                    p4(-16384, -16384, -16384, -16384)),
              p4(9, -5, 0, -32768)};

    repeat (2) @(negedge clk);
    chk("rst ready", 64'(ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst result_id", 64'(result_id), 64'd0);
    chk("rst q8 ready", 64'(ready1), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);

    prev = '0;
    for (int i = 0; i < 8; i++) begin
      run_job(tv[i], prev, $sformatf("vec%0d", i));
      prev = tv[i].exp;
    end

    // Busy: request stays high with new operands through COMPUTE and DONE.
    c0 = done_cnt;
    comp_type = ADD; unit_id = 8'd7; vector_a = p4(1, 1, 1, 1); vector_b = p4(2, 2, 2, 2);
    request = 1'b1;
    @(negedge clk);
    chk("busy ready", 64'(ready), 64'd0);
    vector_a = p4(100, 200, 300, 400); vector_b = p4(5, 5, 5, 5); unit_id = 8'd9; comp_type = SUB;
    @(negedge clk);
    chk("busy done", 64'(done), 64'd1);
    chk("busy result", result, p4(3, 3, 3, 3));
    chk("busy result_id", 64'(result_id), 64'd7);
    @(negedge clk);
    chk("busy ready_after", 64'(ready), 64'd1);
    request = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy done_count", 64'(done_cnt - c0), 64'd1);
    chk("busy result_keep", result, p4(3, 3, 3, 3));
    chk("busy id_keep", 64'(result_id), 64'd7);

    // Reset in the second MATVEC compute cycle aborts the job.
    comp_type = MV; unit_id = 8'd13; vector_a = p4(1, 2, 3, 4); matrix_in = tv[5].m;
    request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("abort ready", 64'(ready), 64'd1);
    chk("abort done", 64'(done), 64'd0);
    chk("abort result", result, 64'd0);
    chk("abort result_id", 64'(result_id), 64'd0);
    c0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("abort no_done", 64'(done_cnt - c0), 64'd0);
    run_job(tv[0], 64'd0, "post_rst");

    // Q8.8 multiply on the second instance.
    comp_type = MUL; unit_id = 8'h21;
    vector_a = p4(16'h0180, 16'h0100, -256, 16'h7FFF);
    vector_b = p4(16'h0180, 16'h0080, 16'h0200, 16'h7FFF);
    request1 = 1'b1;
    @(negedge clk);
    request1 = 1'b0;
    chk("q8 ready_busy", 64'(ready1), 64'd0);
    @(negedge clk);
    chk("q8 done", 64'(done1), 64'd1);
    chk("q8 result", result1, p4(16'h0240, 16'h0080, 16'hFE00, 16'h7FFF));
    chk("q8 result_id", 64'(result_id1), 64'h21);
    @(negedge clk);
    chk("q8 ready_after", 64'(ready1), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
